// File: rtl/run_pattern_pkg.sv
// Shared types and defaults for the run/gap serial pattern generator.
package run_pattern_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StOnes,
        StGap,
        StDone
    } state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter; holds at zero, flags a terminal count of one.
module load_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    logic [W-1:0] cnt_q;

    // Count register: load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/run_pattern_gen.sv
// Serial pattern generator: bursts of run_len ones separated by gap_len zeros.
module run_pattern_gen
    import run_pattern_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] bursts,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_q, gap_q;
    logic             err_q, err_d;
    logic             latch;

    logic             run_ld, run_dec, run_is_one;
    logic [CNT_W-1:0] run_ld_val, run_cnt;
    logic             bur_ld, bur_dec, bur_is_one;
    logic [CNT_W-1:0] bur_ld_val, bur_cnt;
    logic             run_end, bur_last;

    // A zero count is treated as terminal too, so the FSM can never stall.
    assign run_end  = run_is_one || (run_cnt == '0);
    assign bur_last = bur_is_one || (bur_cnt == '0);

    // Next-state, counter control and error-pulse decode.
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        latch      = 1'b0;
        run_ld     = 1'b0;
        run_ld_val = '0;
        run_dec    = 1'b0;
        bur_ld     = 1'b0;
        bur_ld_val = '0;
        bur_dec    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (run_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = StOnes;
                        latch      = 1'b1;
                        run_ld     = 1'b1;
                        run_ld_val = run_len;
                        bur_ld     = 1'b1;
                        bur_ld_val = (bursts == '0) ? CNT_W'(1) : bursts;
                    end
                end
            end
            StOnes: begin
                if (run_end) begin
                    state_d    = StGap;
                    run_ld     = 1'b1;
                    // Minimum gap of one keeps consecutive bursts separate.
                    run_ld_val = (gap_q == '0) ? CNT_W'(1) : gap_q;
                end else begin
                    run_dec = 1'b1;
                end
            end
            StGap: begin
                if (run_end) begin
                    if (bur_last) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StOnes;
                        bur_dec    = 1'b1;
                        run_ld     = 1'b1;
                        run_ld_val = run_q;
                    end
                end else begin
                    run_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d = StIdle;
            err_d   = 1'b0;
            latch   = 1'b0;
            run_ld  = 1'b0;
            run_dec = 1'b0;
            bur_ld  = 1'b0;
            bur_dec = 1'b0;
        end
    end

    // State, error flag and latched pattern fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            run_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (latch) begin
                run_q <= run_len;
                gap_q <= gap_len;
            end
        end
    end

    load_down_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (run_ld),
        .load_val (run_ld_val),
        .dec      (run_dec),
        .cnt      (run_cnt),
        .is_one   (run_is_one)
    );

    load_down_counter #(
        .W (CNT_W)
    ) u_bur_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bur_ld),
        .load_val (bur_ld_val),
        .dec      (bur_dec),
        .cnt      (bur_cnt),
        .is_one   (bur_is_one)
    );

    // Moore outputs decoded from registered state only.
    always_comb begin
        x_out = (state_q == StOnes);
        busy  = (state_q == StOnes) || (state_q == StGap);
        done  = (state_q == StDone);
        err   = err_q;
    end

endmodule

// File: doc/run_pattern_gen.md
RUN_PATTERN_GEN -- requirements
Module: run_pattern_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4: width of run, gap and burst-count fields.
REQ-002 The block SHALL have port clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  in  1  request a pattern; sampled on clk rising edge.
REQ-005 The block SHALL have port abort  in  1  synchronous cancel of the pattern in progress.
REQ-006 The block SHALL have port run_len  in  CNT_W  number of consecutive 1 bits per burst.
REQ-007 The block SHALL have port gap_len  in  CNT_W  number of 0 bits after each burst.
REQ-008 The block SHALL have port bursts  in  CNT_W  number of bursts per pattern.
REQ-009 The block SHALL have port x_out  out  1  serial bit stream, Moore output.
REQ-010 The block SHALL have port busy  out  1  high while in ONES or GAP.
REQ-011 The block SHALL have port done  out  1  one-cycle pulse at normal pattern completion.
REQ-012 The block SHALL have port err  out  1  one-cycle pulse when start is rejected because run_len == 0.

Function
REQ-013 The FSM SHALL have states IDLE, ONES, GAP and DONE; all outputs SHALL be decoded from registered state only (Moore).
REQ-014 x_out SHALL be 1 in ONES and 0 in every other state.
REQ-015 start SHALL be accepted only when busy == 0 (IDLE or DONE); start while busy SHALL be ignored.
REQ-016 On an accepted start, run_len, gap_len and bursts SHALL be latched; later changes to these inputs SHALL NOT affect the pattern in progress.
REQ-017 An accepted start with run_len != 0 SHALL move the FSM to ONES on the same edge, so x_out = 1 in the first cycle after that edge.
REQ-018 An accepted start with run_len == 0 SHALL pulse err for one cycle and move the FSM to IDLE; busy SHALL stay 0.
REQ-019 ONES SHALL last exactly the latched run_len cycles, then go to GAP.
REQ-020 GAP SHALL last max(latched gap_len, 1) cycles, so bursts never merge.
REQ-021 At the end of GAP, if remaining bursts > 1, the remaining count SHALL decrement and the FSM SHALL return to ONES; otherwise it SHALL go to DONE.
REQ-022 A latched bursts value of 0 SHALL be treated as 1.
REQ-023 DONE SHALL last one cycle with done = 1, then go to IDLE unless start is accepted in that cycle, in which case it SHALL go to ONES.
REQ-024 abort SHALL have priority over start and over all transitions; it SHALL force IDLE on the next edge, with no done and no err.
REQ-025 Counters SHALL be CNT_W bits wide, load with the latched value and count down; no wrap-around SHALL occur (terminal count is detected at 1).
REQ-026 Maximum pattern length SHALL be (2^CNT_W - 1) bursts x (2^CNT_W - 1 + gap) cycles, with no overflow.

Reset
REQ-027 While rst is high, the state SHALL be IDLE and x_out, busy, done and err SHALL be 0; counters and latched fields SHALL be 0.
REQ-028 rst asserted mid-pattern SHALL drop x_out to 0 immediately (asynchronously), with no done pulse.
REQ-029 The first start SHALL be honored on the first rising edge after rst deasserts.

Structure
REQ-030 Package run_pattern_pkg SHALL hold the state enum type (IDLE, ONES, GAP, DONE) and the default CNT_W constant.
REQ-031 One sub-module, load_down_counter (parameter W; ports load, load_val, dec, cnt, is_one; async reset), SHALL be instantiated twice: once for the run/gap cycle count and once for the burst count.

Verification
REQ-032 run_len=3, gap_len=2, bursts=1, one start pulse -> x_out = 1,1,1,0,0, then done=1 for one cycle, then IDLE; busy high for exactly 5 cycles.
REQ-033 run_len=2, gap_len=0, bursts=2 -> x_out = 1,1,0,1,1,0, then done; a three-consecutive-ones Moore detector on x_out never fires; run_len=3 makes it fire once per burst.
REQ-034 start with run_len=0 -> err pulse for one cycle; busy, x_out and done stay 0.
REQ-035 run_len=15, gap_len=15, bursts=15 with abort asserted in the 3rd cycle of burst 2 -> x_out=0 and IDLE on the next edge, no done; then start with run_len=1 is accepted.
REQ-036 rst asserted mid-GAP and start held high during and after rst -> all outputs 0 during rst; a new pattern starts on the first edge after release; start held high during busy causes no restart.
REQ-037 start asserted in the DONE cycle -> x_out = 1 in the next cycle, with no IDLE cycle in between.
